// File: rtl/irq_controller.sv
// irq_controller: latches rising edges of peripheral interrupt lines as pending,
// applies per-source masks and a global enable, and presents one request at a
// time to the core as an mcause value with a req/ack/done handshake. The
// watchdog line is non-maskable and always wins arbitration.
module irq_controller #(
   parameter int          NUM_SRC    = 4,
   parameter int          WDT_SRC    = 0,
   parameter logic [31:0] CAUSE_BASE = 32'h8000_0010
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   input  logic               global_en,
   input  logic               mask_we,
   input  logic [NUM_SRC-1:0] mask_wdata,
   output logic [NUM_SRC-1:0] mask,
   output logic [NUM_SRC-1:0] pending,
   output logic               irq_req,
   output logic [31:0]        irq_cause,
   input  logic               irq_ack,
   input  logic               irq_done,
   output logic               in_service
);

   localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [NUM_SRC-1:0] WDT_ONEHOT = NUM_SRC'(1) << WDT_SRC;

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state_reg, state_next;
   logic [NUM_SRC-1:0] prev_reg;
   logic [NUM_SRC-1:0] pending_reg, pending_next;
   logic [NUM_SRC-1:0] mask_reg, mask_next;
   logic [SW-1:0]      sel_reg, sel_next;
   logic               irq_req_reg, irq_req_next;
   logic [31:0]        irq_cause_reg, irq_cause_next;
   logic               in_service_reg, in_service_next;

   logic [NUM_SRC-1:0] rise;
   logic [NUM_SRC-1:0] elig;
   logic [SW-1:0]      win;
   logic               ack_take;

   // A line counts as an edge when it is high now and was low last cycle; the
   // prev register resets to 0 so a line already high after reset still fires.
   assign rise     = irq_src & ~prev_reg;
   assign ack_take = (state_reg == REQ) && irq_ack;

   // The watchdog bit ignores both the mask and the global enable.
   assign elig = pending_reg & (WDT_ONEHOT | (mask_reg & {NUM_SRC{global_en}}));

   // A fresh edge on the acknowledged source beats the clear so it is not lost.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
         assign pending_next[gi] = rise[gi] |
                                   (pending_reg[gi] & ~(ack_take && (sel_reg == SW'(gi))));
      end
   endgenerate

   // The watchdog bit of the stored mask is forced to 1 on every write.
   assign mask_next = mask_we ? (mask_wdata | WDT_ONEHOT) : mask_reg;

   // Arbitration: watchdog first, otherwise the lowest eligible index.
   always_comb begin
      win = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) win = SW'(i);
      end
      if (elig[WDT_SRC]) win = SW'(WDT_SRC);
   end

   // Next-state and registered-output logic; outputs hold unless a transition occurs.
   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      irq_req_next    = irq_req_reg;
      irq_cause_next  = irq_cause_reg;
      in_service_next = in_service_reg;
      case (state_reg)
         IDLE: begin
            if (|elig) begin
               state_next     = REQ;
               sel_next       = win;
               irq_req_next   = 1'b1;
               irq_cause_next = CAUSE_BASE + 32'(win);
            end
         end
         REQ: begin
            if (irq_ack) begin
               state_next      = SERVICE;
               irq_req_next    = 1'b0;
               in_service_next = 1'b1;
            end
         end
         SERVICE: begin
            if (irq_done) begin
               state_next      = IDLE;
               in_service_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and pending/mask registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         prev_reg       <= '0;
         pending_reg    <= '0;
         mask_reg       <= '0;
         sel_reg        <= '0;
         irq_req_reg    <= 1'b0;
         irq_cause_reg  <= '0;
         in_service_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         prev_reg       <= irq_src;
         pending_reg    <= pending_next;
         mask_reg       <= mask_next;
         sel_reg        <= sel_next;
         irq_req_reg    <= irq_req_next;
         irq_cause_reg  <= irq_cause_next;
         in_service_reg <= in_service_next;
      end
   end

   assign mask       = mask_reg | WDT_ONEHOT;
   assign pending    = pending_reg;
   assign irq_req    = irq_req_reg;
   assign irq_cause  = irq_cause_reg;
   assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed vectors with hand-computed expectations for the
// interrupt controller (reset, masking, priority, level hold, stability,
// ack/edge collision, ignored handshakes, asynchronous reset mid-request).
module tb_irq_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  irq_src = '0;
   logic        global_en = 1'b0;
   logic        mask_we = 1'b0;
   logic [3:0]  mask_wdata = '0;
   logic [3:0]  mask;
   logic [3:0]  pending;
   logic        irq_req;
   logic [31:0] irq_cause;
   logic        irq_ack = 1'b0;
   logic        irq_done = 1'b0;
   logic        in_service;

   int n_checks = 0;
   int n_errors = 0;
   int req_cnt;
   logic seen;

   irq_controller #(.NUM_SRC(4), .WDT_SRC(0), .CAUSE_BASE(32'h8000_0010)) dut (
      .clk(clk), .rst(rst), .irq_src(irq_src), .global_en(global_en),
      .mask_we(mask_we), .mask_wdata(mask_wdata), .mask(mask), .pending(pending),
      .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack),
      .irq_done(irq_done), .in_service(in_service)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         $display("check %s: ok (%h)", tag, obs);
      end
   endtask

   task automatic write_mask(input logic [3:0] v);
      mask_we = 1'b1;
      mask_wdata = v;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic ack_cycle();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic done_cycle();
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
   endtask

   // Acknowledge and complete requests as they appear, counting distinct requests.
   task automatic serve_for(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (irq_req && !seen) req_cnt++;
         seen = irq_req;
         irq_ack = irq_req;
         irq_done = in_service;
      end
      irq_ack = 1'b0;
      irq_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("rst_req", 32'(irq_req), 32'd0);
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_mask", 32'(mask), 32'h1);
      check("rst_insvc", 32'(in_service), 32'd0);
      check("rst_cause", irq_cause, 32'h0);

      // Masked source: only bits 1,2 enabled
      write_mask(4'b0110);
      check("mask_rd", 32'(mask), 32'h7);
      global_en = 1'b1;
      irq_src = 4'b0100;
      tick();
      check("m_pend_k", 32'(pending), 32'h4);
      check("m_req_k", 32'(irq_req), 32'd0);
      tick();
      check("m_req_k1", 32'(irq_req), 32'd1);
      check("m_cause", irq_cause, 32'h8000_0012);
      ack_cycle();
      check("m_pend_ack", 32'(pending), 32'h0);
      check("m_insvc", 32'(in_service), 32'd1);
      check("m_req_ack", 32'(irq_req), 32'd0);
      check("m_cause_hold", irq_cause, 32'h8000_0012);
      done_cycle();
      check("m_done", 32'(in_service), 32'd0);
      irq_src = 4'b1000;   // source 3 masked: pending only
      tick();
      tick();
      check("m3_pend", 32'(pending), 32'h8);
      check("m3_noreq", 32'(irq_req), 32'd0);

      // Priority: watchdog, then 1, then 3
      global_en = 1'b0;
      write_mask(4'b1111);
      irq_src = 4'b1011;
      tick();
      check("p_pend", 32'(pending), 32'hB);
      tick();
      check("p_req0", 32'(irq_req), 32'd1);
      check("p_cause0", irq_cause, 32'h8000_0010);
      ack_cycle();
      check("p_pend0", 32'(pending), 32'hA);
      global_en = 1'b1;
      tick();
      check("p_nonest", 32'(irq_req), 32'd0);
      done_cycle();
      tick();
      check("p_cause1", irq_cause, 32'h8000_0011);
      ack_cycle();
      done_cycle();
      tick();
      check("p_cause3", irq_cause, 32'h8000_0013);
      ack_cycle();
      done_cycle();
      check("p_pend_end", 32'(pending), 32'h0);
      irq_src = 4'b0000;
      tick();

      // Level held high yields one request
      req_cnt = 0;
      seen = 1'b0;
      irq_src = 4'b0010;
      serve_for(20);
      check("lvl_once", 32'(req_cnt), 32'd1);
      irq_src = 4'b0000;
      tick();
      tick();
      irq_src = 4'b0010;
      serve_for(10);
      check("lvl_again", 32'(req_cnt), 32'd2);
      check("lvl_pend", 32'(pending), 32'h0);
      irq_src = 4'b0000;
      tick();

      // Stability while in REQ
      irq_src = 4'b0100;
      tick();
      tick();
      check("s_cause", irq_cause, 32'h8000_0012);
      mask_we = 1'b1;
      mask_wdata = 4'b0000;
      global_en = 1'b0;
      irq_src = 4'b0101;
      tick();
      mask_we = 1'b0;
      check("s_req_a", 32'(irq_req), 32'd1);
      check("s_cause_a", irq_cause, 32'h8000_0012);
      check("s_mask", 32'(mask), 32'h1);
      tick();
      tick();
      check("s_req_b", 32'(irq_req), 32'd1);
      check("s_cause_b", irq_cause, 32'h8000_0012);
      ack_cycle();
      check("s_pend_ack", 32'(pending), 32'h1);
      check("s_req_svc", 32'(irq_req), 32'd0);
      done_cycle();
      tick();
      check("s_wdt_req", 32'(irq_req), 32'd1);
      check("s_wdt_cause", irq_cause, 32'h8000_0010);
      ack_cycle();
      done_cycle();
      irq_src = 4'b0000;
      global_en = 1'b1;
      write_mask(4'b1111);

      // Collision: new edge on sel in the ack cycle
      irq_src = 4'b0010;
      tick();
      tick();
      check("c_cause", irq_cause, 32'h8000_0011);
      irq_src = 4'b0000;
      tick();
      irq_src = 4'b0010;
      ack_cycle();
      check("c_pend", 32'(pending), 32'h2);
      check("c_insvc", 32'(in_service), 32'd1);
      done_cycle();
      check("c_req_done", 32'(irq_req), 32'd0);
      tick();
      check("c_rereq", 32'(irq_req), 32'd1);
      check("c_recause", irq_cause, 32'h8000_0011);
      ack_cycle();
      done_cycle();
      irq_src = 4'b0000;
      tick();

      // Handshakes outside their states are ignored
      done_cycle();
      check("i_done", 32'(in_service), 32'd0);
      ack_cycle();
      check("i_ack_svc", 32'(in_service), 32'd0);
      check("i_ack_req", 32'(irq_req), 32'd0);

      // Asynchronous reset mid-REQ
      irq_src = 4'b0100;
      tick();
      tick();
      check("r_req_pre", 32'(irq_req), 32'd1);
      irq_src = 4'b0000;
      #2 rst = 1'b0;
      #1;
      check("r_req", 32'(irq_req), 32'd0);
      check("r_pend", 32'(pending), 32'h0);
      check("r_mask", 32'(mask), 32'h1);
      check("r_cause", irq_cause, 32'h0);
      #1 rst = 1'b1;
      tick();
      tick();
      check("r_idle_req", 32'(irq_req), 32'd0);
      check("r_idle_svc", 32'(in_service), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
